// File: rtl/gbt_pll_ctrl_pkg.sv
// Shared types and constants for the GBT frame-clock PLL controller.
// Holds the controller state encoding and lock-loss counter sizing.
package gbt_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILIZE,
    READY,
    FAULT
  } pll_ctrl_state_t;

  localparam int LOSS_CNT_W = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'd255;

endpackage

// File: rtl/gbt_sync_2ff.sv
// Two-flop synchronizer for asynchronous status inputs.
// Async active-high reset clears both stages.
module gbt_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/gbt_frameclk_pll_ctrl.sv
// Frame-clock PLL reset sequencer, lock supervisor and ready qualifier.
// Define GBT_PLL_CTRL_LOSS_CNT_EN to build the lock-loss event counter.
module gbt_frameclk_pll_ctrl
  import gbt_pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 120000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 7,
  parameter int unsigned CNT_W               = 20
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  clr_fault,
  output logic                  pll_rst,
  output logic                  frameclk_ready,
  output logic                  retry_exhausted,
  output logic [LOSS_CNT_W-1:0] lock_lost_cnt
);

  localparam int RTY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT   = RTY_W'(MAX_RETRIES);

  pll_ctrl_state_t  state_q, state_d;
  pll_ctrl_state_t  fail_state;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
  logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
  logic [RTY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic [RTY_W-1:0] retry_inc;
  logic             locked_s;
  logic             timeout_hit;
  logic             pll_rst_q, ready_q, exhausted_q;

  gbt_sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d_i (pll_locked),
    .q_o (locked_s)
  );

  assign timeout_hit = (timeout_cnt_q == TO_LAST);
  assign retry_inc   = retry_cnt_q + RTY_W'(1);
  assign fail_state  = (retry_inc == RTY_LIMIT) ? FAULT : RESET_PLL;

  always_comb begin
    state_d       = state_q;
    pulse_cnt_d   = pulse_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    stable_cnt_d  = stable_cnt_q;
    retry_cnt_d   = retry_cnt_q;
    unique case (state_q)
      RESET_PLL: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          state_d       = WAIT_LOCK;
          pulse_cnt_d   = '0;
          timeout_cnt_d = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
        if (timeout_hit) begin
          retry_cnt_d = retry_inc;
          state_d     = fail_state;
        end else if (locked_s) begin
          state_d      = STABILIZE;
          stable_cnt_d = '0;
        end
      end
      STABILIZE: begin
        // Timeout budget spans the whole acquisition, chatter included.
        timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
        if (timeout_hit) begin
          retry_cnt_d  = retry_inc;
          stable_cnt_d = '0;
          state_d      = fail_state;
        end else if (!locked_s) begin
          stable_cnt_d = '0;
          state_d      = WAIT_LOCK;
        end else if (stable_cnt_q == STABLE_LAST) begin
          stable_cnt_d = '0;
          retry_cnt_d  = '0;
          state_d      = READY;
        end else begin
          stable_cnt_d = stable_cnt_q + CNT_W'(1);
        end
      end
      READY: begin
        if (!locked_s) begin
          state_d = RESET_PLL;
        end
      end
      FAULT: begin
        if (clr_fault) begin
          retry_cnt_d = '0;
          state_d     = RESET_PLL;
        end
      end
      default: begin
        state_d = RESET_PLL;
      end
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q       <= RESET_PLL;
      pulse_cnt_q   <= '0;
      timeout_cnt_q <= '0;
      stable_cnt_q  <= '0;
      retry_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pulse_cnt_q   <= pulse_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      stable_cnt_q  <= stable_cnt_d;
      retry_cnt_q   <= retry_cnt_d;
    end
  end

  // Outputs register the next-state decode, so they track state_q exactly.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pll_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      exhausted_q <= 1'b0;
    end else begin
      pll_rst_q   <= (state_d == RESET_PLL) || (state_d == FAULT);
      ready_q     <= (state_d == READY);
      exhausted_q <= (state_d == FAULT);
    end
  end

  assign pll_rst         = pll_rst_q;
  assign frameclk_ready  = ready_q;
  assign retry_exhausted = exhausted_q;

`ifdef GBT_PLL_CTRL_LOSS_CNT_EN
  logic                  lock_loss;
  logic [LOSS_CNT_W-1:0] loss_cnt_q;

  assign lock_loss = (state_q == READY) && !locked_s;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else if (lock_loss && (loss_cnt_q != LOSS_CNT_MAX)) begin
      loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
    end
  end

  assign lock_lost_cnt = loss_cnt_q;
`else
  assign lock_lost_cnt = '0;
`endif

endmodule

// File: tb/tb_gbt_frameclk_pll_ctrl.sv
// Directed bench for the frame-clock PLL controller.
// Expected latencies and levels queue at stimulus time, compared on observation.
module tb_gbt_frameclk_pll_ctrl;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       clr_fault;
  logic       pll_rst;
  logic       frameclk_ready;
  logic       retry_exhausted;
  logic [7:0] lock_lost_cnt;

  typedef struct {
    string tag;
    int    exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;
  int  n;
  int  loss_model;

`ifdef GBT_PLL_CTRL_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  gbt_frameclk_pll_ctrl #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (64),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2),
    .CNT_W               (20)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .clr_fault       (clr_fault),
    .pll_rst         (pll_rst),
    .frameclk_ready  (frameclk_ready),
    .retry_exhausted (retry_exhausted),
    .lock_lost_cnt   (lock_lost_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic push(input string tag, input int exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input int obs);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty observed=%0d", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  function automatic logic sig_of(input int sel);
    case (sel)
      0:       return pll_rst;
      1:       return frameclk_ready;
      default: return retry_exhausted;
    endcase
  endfunction

  // Edges until the selected output reaches val; -1 when the bound expires.
  task automatic edges_until(input int sel, input logic val,
                             input int max, output int cnt);
    cnt = 0;
    forever begin
      tick();
      cnt++;
      if (sig_of(sel) === val) return;
      if (cnt >= max) begin
        cnt = -1;
        return;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    push({pfx, "_pll_rst"}, 1);   pop_chk(int'(pll_rst));
    push({pfx, "_ready"}, 0);     pop_chk(int'(frameclk_ready));
    push({pfx, "_exhausted"}, 0); pop_chk(int'(retry_exhausted));
    push({pfx, "_lost_cnt"}, 0);  pop_chk(int'(lock_lost_cnt));
  endtask

  task automatic lose_and_relock(input string pfx);
    pll_locked = 1'b0;
    push({pfx, "_fall_lat"}, 3);
    edges_until(1, 1'b0, 10, n);
    pop_chk(n);
    push({pfx, "_pulse"}, 4);
    edges_until(0, 1'b0, 20, n);
    pop_chk(n);
    pll_locked = 1'b1;
    push({pfx, "_rise_lat"}, 11);
    edges_until(1, 1'b1, 40, n);
    pop_chk(n);
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    clr_fault  = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");

    rst = 1'b0;
    push("init_pulse", 4);
    edges_until(0, 1'b0, 20, n);
    pop_chk(n);
    repeat (10) tick();
    pll_locked = 1'b1;
    push("nominal_lat", 11);
    edges_until(1, 1'b1, 40, n);
    pop_chk(n);
    push("nominal_exhausted", 0);
    pop_chk(int'(retry_exhausted));

    pll_locked = 1'b0;
    push("loss1_fall_lat", 3);
    edges_until(1, 1'b0, 10, n);
    pop_chk(n);
    push("loss1_pll_rst", 1);
    pop_chk(int'(pll_rst));
    loss_model = 1;
    push("loss1_cnt", LOSS_EN ? loss_model : 0);
    pop_chk(int'(lock_lost_cnt));
    push("loss1_pulse", 4);
    edges_until(0, 1'b0, 20, n);
    pop_chk(n);

    pll_locked = 1'b1;
    repeat (6) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    push("chatter_lat", 11);
    edges_until(1, 1'b1, 40, n);
    pop_chk(n);
    push("chatter_exhausted", 0);
    pop_chk(int'(retry_exhausted));

    for (int i = 0; i < 300; i++) begin
      lose_and_relock("loss_loop");
      loss_model = (loss_model < 255) ? loss_model + 1 : 255;
      if (i == 99 || i == 299) begin
        push("loss_cnt", LOSS_EN ? loss_model : 0);
        pop_chk(int'(lock_lost_cnt));
      end
    end

    pll_locked = 1'b0;
    push("to_fall_lat", 3);
    edges_until(1, 1'b0, 10, n);
    pop_chk(n);
    push("to_pulse1", 4);
    edges_until(0, 1'b0, 20, n);
    pop_chk(n);
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    push("to_wait1", 63);
    edges_until(0, 1'b1, 100, n);
    pop_chk(n);
    push("to_mid_exhausted", 0);
    pop_chk(int'(retry_exhausted));
    push("to_pulse2", 4);
    edges_until(0, 1'b0, 20, n);
    pop_chk(n);
    push("to_wait2", 64);
    edges_until(0, 1'b1, 100, n);
    pop_chk(n);
    push("fault_exhausted", 1);
    pop_chk(int'(retry_exhausted));
    repeat (20) tick();
    push("fault_hold_rst", 1);
    pop_chk(int'(pll_rst));
    push("fault_hold_exh", 1);
    pop_chk(int'(retry_exhausted));
    push("fault_ready", 0);
    pop_chk(int'(frameclk_ready));

    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    push("clr_exhausted", 0);
    pop_chk(int'(retry_exhausted));
    push("clr_pll_rst", 1);
    pop_chk(int'(pll_rst));
    push("clr_pulse", 4);
    edges_until(0, 1'b0, 20, n);
    pop_chk(n);
    push("clr_wait", 64);
    edges_until(0, 1'b1, 100, n);
    pop_chk(n);
    push("clr_retry_exhausted", 0);
    pop_chk(int'(retry_exhausted));
    push("clr_retry_pulse", 4);
    edges_until(0, 1'b0, 20, n);
    pop_chk(n);
    pll_locked = 1'b1;
    push("clr_relock_lat", 11);
    edges_until(1, 1'b1, 40, n);
    pop_chk(n);

    pll_locked = 1'b0;
    push("mid_fall_lat", 3);
    edges_until(1, 1'b0, 10, n);
    pop_chk(n);
    push("mid_pulse", 4);
    edges_until(0, 1'b0, 20, n);
    pop_chk(n);
    pll_locked = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    repeat (3) tick();
    rst = 1'b0;
    push("midrst_pulse", 4);
    edges_until(0, 1'b0, 20, n);
    pop_chk(n);
    push("midrst_ready_lat", 9);
    edges_until(1, 1'b1, 40, n);
    pop_chk(n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gbt_frameclk_pll_ctrl.md
# gbt_frameclk_pll_ctrl

Control and supervision block for the GBT frame-clock PLL. It drives the PLL reset and consumes the PLL `locked` flag. It sequences reset pulses, waits for lock with a timeout and bounded retries, and debounces lock. It declares the frame clock usable only after `locked` has been stable for a programmable time, and counts lock-loss events. It sits beside the 120 MHz → 40 MHz frame-clock PLL, runs on the free-running PLL reference clock, and gates release of the GBT TX/RX frame-clock-domain logic.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, 16: `pll_rst` pulse width in refclk cycles (≥1).
- `LOCK_TIMEOUT_CYCLES`, 120000: maximum cycles from PLL reset release to stable lock (1 ms at 120 MHz).
- `LOCK_STABLE_CYCLES`, 1024: consecutive cycles of synchronized lock required before ready (≥1).
- `MAX_RETRIES`, 7: failed lock attempts allowed before entering FAULT (≥1).
- `CNT_W`, 20: timer width; must hold the largest of the three cycle parameters.

Ports:
- `refclk` in 1: free-running reference clock; the only clock.
- `rst` in 1: reset, asynchronous and active-high.
- `pll_locked` in 1: PLL lock flag, asynchronous to `refclk`.
- `clr_fault` in 1: single-cycle pulse; leaves FAULT.
- `pll_rst` out 1: reset to the PLL, active-high.
- `frameclk_ready` out 1: frame clock stable and usable.
- `retry_exhausted` out 1: high while in FAULT.
- `lock_lost_cnt` out 8: saturating count of lock losses from READY.

## Operation
- `pll_locked` passes through a 2-FF synchronizer to `locked_s`. Only `locked_s` is used internally.
- States: RESET_PLL, WAIT_LOCK, STABILIZE, READY, FAULT.
- **RESET_PLL:**
  - `pll_rst` = 1 for exactly `RST_PULSE_CYCLES` cycles, then go to WAIT_LOCK.
  - `timeout_cnt` is cleared on exit.
- **WAIT_LOCK:**
  - `pll_rst` = 0 and `timeout_cnt` increments.
  - `locked_s` = 1 → STABILIZE with `stable_cnt` = 0.
  - Timeout → RESET_PLL.
- **STABILIZE:**
  - `timeout_cnt` keeps running; it is not cleared.
  - `stable_cnt` increments while `locked_s` = 1.
  - `locked_s` = 0 → WAIT_LOCK. `stable_cnt` clears; no retry is charged.
  - `stable_cnt` == `LOCK_STABLE_CYCLES`−1 with `locked_s` = 1 → READY and `retry_cnt` clears.
  - Timeout → RESET_PLL.
- **Timeout:** `timeout_cnt` == `LOCK_TIMEOUT_CYCLES`−1 in WAIT_LOCK or STABILIZE.
  - `retry_cnt` increments.
  - If the new `retry_cnt` == `MAX_RETRIES` → FAULT, otherwise → RESET_PLL.
  - Timeout takes priority over the lock transitions in the same cycle.
- **READY:**
  - `frameclk_ready` = 1.
  - `locked_s` = 0 → RESET_PLL, and `lock_lost_cnt` increments, saturating at 255.
- **FAULT:**
  - `pll_rst` = 1 held and `retry_exhausted` = 1.
  - `clr_fault` = 1 → RESET_PLL with `retry_cnt` cleared.
  - `clr_fault` is ignored in every other state.
- `lock_lost_cnt` is cleared only by `rst`.

## Timing
- Reset values while `rst` is high:
  - state RESET_PLL, all counters 0, synchronizer 0.
  - `pll_rst` = 1, `frameclk_ready` = 0, `retry_exhausted` = 0, `lock_lost_cnt` = 0.
- After `rst` deasserts, `pll_rst` stays high for `RST_PULSE_CYCLES` more cycles.
- All outputs are registered and decode the current state.
- Synchronizer latency: 2 cycles.
- Ready latency: `frameclk_ready` rises `LOCK_STABLE_CYCLES`+1 cycles after `locked_s` first goes high in WAIT_LOCK. That is `LOCK_STABLE_CYCLES`+3 edges after `pll_locked` rises.
- Lock loss: `frameclk_ready` falls 3 edges after `pll_locked` falls. `pll_rst` rises in the same cycle.
- Mid-operation `rst` aborts any state immediately; no counter survives except through reset values.

## Configuration
- `GBT_PLL_CTRL_LOSS_CNT_EN` defined: the `lock_lost_cnt` counter is built as described.
- Not defined: `lock_lost_cnt` is tied to 0 and no counter logic is built. State behaviour is identical in both cases.

## Structure
- Package `gbt_pll_ctrl_pkg`:
  - state enum `pll_ctrl_state_t`
  - `LOSS_CNT_W` = 8
  - `LOSS_CNT_MAX` = 255
- Sub-module `gbt_sync_2ff`: 2-FF synchronizer with async active-high reset. Reused for other async status inputs.

## Test plan
All scenarios use `RST_PULSE_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=64, `LOCK_STABLE_CYCLES`=8, `MAX_RETRIES`=2.
- Nominal lock: release `rst`, raise `pll_locked` 10 cycles after `pll_rst` falls → `pll_rst` high for 4 cycles after reset; `frameclk_ready` rises exactly 11 edges after `pll_locked`.
- Chatter: toggle `pll_locked` low for 1 cycle at stable count 5 → back to WAIT_LOCK; ready rises 8+1 cycles after `locked_s` returns; `retry_exhausted` = 0.
- Timeout and fault: hold `pll_locked` = 0 → two 4-cycle `pll_rst` pulses 64 cycles apart, then FAULT with `pll_rst` = 1 and `retry_exhausted` = 1; pulse `clr_fault` → RESET_PLL, `retry_exhausted` = 0.
- Lock loss: drop `pll_locked` in READY 300 times → `frameclk_ready` falls 3 edges after each drop; `lock_lost_cnt` saturates at 255, or reads 0 with the macro undefined.
- Reset mid-STABILIZE: assert `rst` → all outputs at reset values in the same cycle; full sequence restarts after release.
